// File: rtl/xor_cipher_pkg.sv
// xor_cipher_pkg: shared types and sizing for the XOR cipher controller
package xor_cipher_pkg;
   localparam int DW = 8;
   localparam int KEY_LEN_DEF = 4;
   typedef enum logic [1:0] {IDLE, LOAD_KEY, RUN} state_t;
   function automatic int clog2(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/xor_cipher_ctrl_bitwise_xor.sv
// bitwise_xor: combinational byte XOR datapath
module bitwise_xor #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);
   assign y = a ^ b;
endmodule

// File: rtl/xor_cipher_ctrl.sv
// xor_cipher_ctrl: serial key loader and rolling-key XOR byte streamer
module xor_cipher_ctrl
   import xor_cipher_pkg::*;
#(
   parameter int KEY_LEN = KEY_LEN_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          key_load,
   input  logic          key_valid,
   input  logic [DW-1:0] key_byte,
   output logic          key_ready,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   input  logic          in_last,
   output logic          in_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   input  logic          out_ready,
   output logic          key_loaded,
   output logic          busy
);
   localparam int IW = clog2(KEY_LEN);
   localparam logic [IW-1:0] LAST_IDX = IW'(KEY_LEN - 1);

   state_t        state, state_nx;
   logic [DW-1:0] key [KEY_LEN];
   logic [IW-1:0] idx, kcnt;
   logic [DW-1:0] xor_y;
   logic          frame_active, key_acc, in_acc, key_done, reload, start_load;

   bitwise_xor #(.W(DW)) u_xor (.a(in_data), .b(key[idx]), .y(xor_y));

   // a reload is only safe once no frame is open and the output is empty
   always_comb begin
      key_ready  = state == LOAD_KEY;
      in_ready   = state == RUN && (!out_valid || out_ready);
      key_acc    = key_valid && key_ready;
      in_acc     = in_valid && in_ready;
      key_done   = key_acc && kcnt == LAST_IDX;
      reload     = state == RUN && key_load && !frame_active && !out_valid;
      state_nx   = ((state == IDLE && key_load) || reload) ? LOAD_KEY :
                   key_done ? RUN : state;
      start_load = state_nx == LOAD_KEY && state != LOAD_KEY;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         for (int i = 0; i < KEY_LEN; i++) key[i] <= '0;
         idx          <= '0;
         kcnt         <= '0;
         out_data     <= '0;
         out_valid    <= 1'b0;
         out_last     <= 1'b0;
         key_loaded   <= 1'b0;
         frame_active <= 1'b0;
      end else begin
         state <= state_nx;
         if (start_load) begin
            key_loaded <= 1'b0;
            kcnt       <= '0;
         end
         if (key_acc) begin
            key[kcnt] <= key_byte;
            kcnt      <= key_done ? '0 : kcnt + 1'b1;
         end
         if (key_done) begin
            key_loaded <= 1'b1;
            idx        <= '0;
         end
         if (in_acc) begin
            out_data     <= xor_y;
            out_last     <= in_last;
            out_valid    <= 1'b1;
            idx          <= (in_last || idx == LAST_IDX) ? '0 : idx + 1'b1;
            frame_active <= !in_last;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   assign busy = frame_active || out_valid;
endmodule

// File: doc/xor_cipher_ctrl.md
Name: xor_cipher_ctrl

Overview:
Sequencing controller for the 8-bit XOR cipher datapath. It loads a multi-byte key serially and streams data bytes through the bitwise_xor datapath, selecting key byte key[idx] per data byte with a rolling index. Byte streams use valid/ready handshakes on both sides with a registered output stage. It sits between the UART/byte-source front end and the byte sink of the FPGA cryptosystem. Encrypt and decrypt are the same operation.

Parameters:
KEY_LEN, 4, number of key bytes (2..16); the key index wraps modulo KEY_LEN.
DW, 8, data/key byte width; fixed at 8 for this design.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
key_load  in  1  single-cycle pulse requesting a new key load
key_valid  in  1  key byte valid
key_byte  in  8  key byte; key[0] arrives first
key_ready  out  1  controller accepting key bytes
in_valid  in  1  plaintext/ciphertext byte valid
in_data  in  8  input byte
in_last  in  1  marks the final byte of a frame
in_ready  out  1  controller accepting input byte
out_valid  out  1  output byte valid
out_data  out  8  in_data XOR key[idx]
out_last  out  1  in_last delayed with its byte
out_ready  in  1  sink accepting output byte
key_loaded  out  1  complete key is held; cipher is usable
busy  out  1  frame in progress or output occupied

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous, active-low, on rst_n.
  - rst_n=0 at a clk edge sets: state=IDLE; key registers, idx, kcnt and out_data to 0; out_valid, out_last, key_loaded and frame_active to 0.
- Reset mid-operation: a partial key or frame is discarded and the output is dropped.
- States: IDLE, LOAD_KEY, RUN.
- IDLE:
  - key_ready=0 and in_ready=0.
  - key_load=1 moves to LOAD_KEY, clears key_loaded and sets kcnt=0.
- LOAD_KEY:
  - key_ready=1 and in_ready=0.
  - Each key_valid&&key_ready cycle writes key[kcnt]=key_byte and increments kcnt.
  - Accepting byte KEY_LEN-1 moves to RUN, sets key_loaded=1 and sets idx=0.
  - key_load while in LOAD_KEY is ignored.
- RUN:
  - key_ready=0.
  - in_ready = !out_valid || out_ready, giving full throughput with a single output register.
- Accept (in_valid&&in_ready):
  - Next cycle: out_data = in_data ^ key[idx], out_last = in_last, out_valid = 1. Latency is 1 cycle.
  - idx becomes 0 if in_last or idx==KEY_LEN-1; otherwise idx+1.
  - frame_active is set when the accepted byte has in_last=0 and cleared when in_last=1.
- Output handshake:
  - out_valid&&out_ready with no new accept clears out_valid.
  - A simultaneous drain and accept reloads the output register in the same cycle.
  - out_data and out_last stay stable while out_valid=1 and out_ready=0.
- Key reload:
  - key_load in RUN is honoured only when frame_active=0 and out_valid=0. It then goes to LOAD_KEY.
  - Otherwise key_load is ignored, not queued.
- Ignored inputs: key_valid outside LOAD_KEY and in_valid outside RUN are ignored, and their ready signals are low.
- busy = frame_active || out_valid.

Decomposition:
- Package xor_cipher_pkg:
  - state enum (IDLE, LOAD_KEY, RUN)
  - DW=8
  - default KEY_LEN=4
  - index width function clog2(KEY_LEN)
- Sub-module: one instance of the existing bitwise_xor (a=in_data, b=key[idx]) as the combinational datapath feeding the output register.
- The FSM, key register file, index counter and output stage stay in xor_cipher_ctrl.

Test Plan:
- Basic encrypt:
  - Load key A5,3C,0F,F0, then stream 00,FF,11,22,33 (last on 33) with out_ready=1.
  - Expect out A5,C3,1E,D2,96 with out_last on 96, key_loaded=1, and one byte per cycle after 1-cycle latency.
- Frame index reset:
  - Send frame 00,00(last), then frame 00.
  - Expect A5,3C, then A5 (idx restarts at 0).
- Backpressure:
  - Hold out_ready=0 for 3 cycles with in_valid=1.
  - Expect in_ready=0 after the first accept and out_data held at A5.
  - On release, expect no loss or duplication and the order preserved.
- Key reload gating:
  - Pulse key_load mid-frame: expect it ignored and state RUN.
  - Pulse key_load after last is drained: expect key_ready=1.
  - Load 01,02,03,04, then send 10: expect 11.
- Round trip:
  - Feed the encrypted output A5,C3,1E,D2,96 back in as a new frame with the same key.
  - Expect the original 00,FF,11,22,33.
- Reset mid-operation:
  - Drive rst_n=0 for 1 cycle during LOAD_KEY (after 2 key bytes) and during a RUN frame with out_valid=1.
  - Expect IDLE, all outputs 0, key_loaded=0, and in_ready=0 until a full reload.
